// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, FSM states and alignment check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_ST_RD,
        S_ST_WR,
        S_RESP
    } lsu_state_e;

    // funct3[1] set covers W and the unsupported encodings 011/110/111, all handled as words.
    function automatic logic is_word(input logic [2:0] funct3);
        return funct3[1];
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        if (is_word(funct3)) begin
            return addr_lo != 2'b00;
        end else if (funct3[0]) begin
            return addr_lo[0];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian sub-word extract/extend for loads and merge for stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte   = 8'h00;
        sel_half   = 16'h0000;
        load_data  = word;
        store_word = wdata;

        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        // Halfwords use only offset[1], so a low-bit misalignment is silently aligned down.
        sel_half = offset[1] ? word[31:16] : word[15:0];

        if (!is_word(funct3)) begin
            if (funct3[0]) begin
                load_data  = {{16{sel_half[15] & ~funct3[2]}}, sel_half};
                store_word = offset[1] ? {wdata[15:0], word[15:0]}
                                       : {word[31:16], wdata[15:0]};
            end else begin
                load_data = {{24{sel_byte[7] & ~funct3[2]}}, sel_byte};
                case (offset)
                    2'd0:    store_word = {word[31:8], wdata[7:0]};
                    2'd1:    store_word = {word[31:16], wdata[7:0], word[7:0]};
                    2'd2:    store_word = {word[31:24], wdata[7:0], word[15:0]};
                    default: store_word = {wdata[7:0], word[23:0]};
                endcase
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store controller with read-modify-write sub-word stores.
// Optional LSU_MISALIGN_CHECK_EN: flag misaligned H/W accesses with rsp_err instead of aligning down.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);

    lsu_state_e            state;
    lsu_state_e            state_next;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DM_ADDRESS-1:0] a_q;
    logic [DATA_W-1:0]     merged_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     store_word;
    logic                  req_mis;
    logic                  accept;
    logic                  unused_addr_hi;

    assign accept         = req_valid && (state == S_IDLE);
    assign unused_addr_hi = ^req_addr[DATA_W-1:DM_ADDRESS+2];

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;

    assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_mis;
        end
    end

    assign rsp_err = (state == S_RESP) && err_q;
`else
    assign req_mis = 1'b0;
    assign rsp_err = 1'b0;
`endif

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .word       (rd),
        .offset     (offset_q),
        .funct3     (funct3_q),
        .wdata      (merged_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // merged_q holds the store data until ST_RD overwrites it with the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= 3'b000;
            offset_q <= 2'b00;
            a_q      <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                a_q      <= req_addr[DM_ADDRESS+1:2];
                merged_q <= req_wdata;
                rdata_q  <= '0;
            end
            if (state == S_LD_RD) begin
                rdata_q <= load_data;
            end
            if (state == S_ST_RD) begin
                merged_q <= store_word;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_mis) begin
                        state_next = S_RESP;
                    end else if (!req_we) begin
                        state_next = S_LD_RD;
                    end else if (is_word(req_funct3)) begin
                        state_next = S_ST_WR;
                    end else begin
                        state_next = S_ST_RD;
                    end
                end
            end
            S_LD_RD: state_next = S_RESP;
            S_ST_RD: state_next = S_ST_WR;
            S_ST_WR: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        rsp_rdata = rdata_q;
        MemRead   = (state == S_LD_RD) || (state == S_ST_RD);
        MemWrite  = (state == S_ST_WR);
        a         = a_q;
        wd        = (state == S_ST_WR) ? merged_q : '0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and random requests against a word-memory model and reference.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    assign rd = mem[a];

    always @(posedge clk) begin
        if (MemWrite) mem[a] <= wd;
    end

    lsu_ctrl #(
        .DM_ADDRESS (9),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .rd         (rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]     <= val;
        ref_mem[idx]  = val;
    endtask

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output logic [31:0] exp_rdata, output logic exp_err, output int exp_lat,
                         output int exp_nrd, output int exp_nwr, output logic [31:0] exp_word);
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        int          sz;
        int          off;
        bit          mis;
        w   = ref_mem[addr[10:2]];
        sz  = f3[1] ? 4 : (f3[0] ? 2 : 1);
        mis = CHK && ((int'(addr[1:0]) % sz) != 0);
        off = (int'(addr[1:0]) / sz) * sz;
        exp_word  = w;
        exp_rdata = 32'h0;
        exp_err   = mis;
        exp_nwr   = 0;
        if (mis) begin
            exp_lat = 1;
            exp_nrd = 0;
        end else if (!we) begin
            exp_lat = 2;
            exp_nrd = 1;
            v = w >> (8 * off);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
            end
            exp_rdata = v;
        end else begin
            exp_nwr = 1;
            if (sz == 4) begin
                exp_lat  = 2;
                exp_nrd  = 0;
                exp_word = wdata;
            end else begin
                exp_lat  = 3;
                exp_nrd  = 1;
                mask     = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
                exp_word = (w & ~mask) | ((wdata << (8 * off)) & mask);
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        logic        exp_err;
        int          exp_lat, exp_nrd, exp_nwr;
        int          lat, nrd, nwr, both, busy_ready;
        bit          got;
        logic [8:0]  a_seen;
        logic [31:0] rdata_seen;
        logic        err_seen;
        model(we, f3, addr, wdata, exp_rdata, exp_err, exp_lat, exp_nrd, exp_nwr, exp_word);
        @(negedge clk);
        check("ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Garbage held with req_valid high while busy must be neither accepted nor used.
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0; nrd = 0; nwr = 0; both = 0; busy_ready = 0; got = 0;
        a_seen = 9'h0; rdata_seen = 32'h0; err_seen = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (MemRead) begin nrd++; a_seen = a; end
            if (MemWrite) begin nwr++; a_seen = a; end
            if (MemRead && MemWrite) both++;
            if (rsp_valid) begin
                got        = 1;
                rdata_seen = rsp_rdata;
                err_seen   = rsp_err;
                req_valid  = 1'b0;
            end else if (req_ready) begin
                busy_ready++;
            end
        end
        req_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("rsp_rdata", rdata_seen, exp_rdata);
        check("rsp_err", err_seen, exp_err);
        check("memread_cycles", nrd, exp_nrd);
        check("memwrite_cycles", nwr, exp_nwr);
        check("rd_wr_overlap", both, 0);
        check("ready_while_busy", busy_ready, 0);
        if (exp_nrd + exp_nwr > 0) check("word_addr", a_seen, addr[10:2]);
        check("mem_word", mem[addr[10:2]], exp_word);
        ref_mem[addr[10:2]] = exp_word;
        last_rdata = rdata_seen;
    endtask

    initial begin
        int quiet_wr;
        for (int i = 0; i < 512; i++) set_word(i, $urandom);
        #12;
        check("reset_out_a", {req_ready, rsp_valid, rsp_err, MemRead, MemWrite, a},
              {1'b1, 4'b0, 9'h0});
        check("reset_out_b", {wd, rsp_rdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        set_word(4, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_const", last_rdata, 32'hDEADBEEF);
        set_word(4, 32'h80FF7F01);
        run_req(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_const", last_rdata, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_const", last_rdata, 32'h00000080);
        set_word(8, 32'h11223344);
        run_req(1'b1, 3'b000, 32'h21, 32'h000000AB);
        run_req(1'b0, 3'b010, 32'h20, 32'h0);
        check("sb_readback", last_rdata, 32'h1122AB44);
        set_word(0, 32'h0);
        run_req(1'b1, 3'b001, 32'h02, 32'h00005566);
        check("sh_word0", mem[0], 32'h55660000);
        run_req(1'b1, 3'b010, 32'h04, 32'hCAFEF00D);
        check("sw_word1", mem[1], 32'hCAFEF00D);
        run_req(1'b0, 3'b001, 32'h05, 32'h0);
        run_req(1'b0, 3'b101, 32'h07, 32'h0);
        run_req(1'b0, 3'b011, 32'h12, 32'h0);
        run_req(1'b1, 3'b111, 32'h31, 32'h12345678);

        // Reset during the read half of an SB must leave memory untouched.
        set_word(8, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("st_rd_reached", MemRead, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_a", {req_ready, rsp_valid, rsp_err, MemRead, MemWrite, a},
              {1'b1, 4'b0, 9'h0});
        check("midrst_out_b", {wd, rsp_rdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_wr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (MemWrite) quiet_wr++;
        end
        check("no_write_after_reset", quiet_wr, 0);
        check("mem_after_reset", mem[8], 32'h11223344);
        run_req(1'b1, 3'b000, 32'h22, 32'h000000CD);
        check("post_reset_sb", mem[8], 32'h11CD3344);

        for (int n = 0; n < 300; n++) begin
            run_req(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
